// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Holds the FSM encoding, slot index type and the slot price table.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CREDIT      = 3'd1,
        ST_ROW_LATCHED = 3'd2,
        ST_CHECK       = 3'd3,
        ST_VEND        = 3'd4,
        ST_CHANGE      = 3'd5
    } vend_state_t;

    typedef logic [3:0] slot_idx_t;
    typedef logic [1:0] btn_idx_t;

    // Prices in cents, indexed by row*4+col (A1..A4, B1..B4, ...).
    localparam logic [15:0] PRICE_TABLE [0:15] = '{
        16'd50,  16'd100, 16'd150, 16'd200,
        16'd250, 16'd250, 16'd275, 16'd300,
        16'd100, 16'd125, 16'd150, 16'd175,
        16'd200, 16'd225, 16'd250, 16'd300
    };

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for one-hot inputs.
    function automatic btn_idx_t enc4(input logic [3:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction

endpackage

// File: rtl/vend_price_rom.sv
// Combinational slot-to-price lookup.
// Shared between the transaction sequencer and the display logic.
module vend_price_rom
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 16
) (
    input  logic [3:0]          slot,
    output logic [CREDIT_W-1:0] price
);

    assign price = CREDIT_W'(PRICE_TABLE[slot]);

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit, selection, price check,
// dispense handshake, change/refund handshake, timeout and cancel.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CREDIT_W       = 16,
    parameter int MAX_CREDIT     = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic [3:0]          row_sel,
    input  logic [3:0]          col_sel,
    input  logic                cancel,
    output logic                vend_req,
    output logic [3:0]          vend_slot,
    input  logic                vend_done,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_out,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit_out,
    output logic [CREDIT_W-1:0] price_out,
    output logic                success,
    output logic                err_invalid,
    output logic                err_funds,
    output logic                coin_reject
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n;
    logic [CREDIT_W-1:0] price_q, price_n;
    btn_idx_t            row_idx, row_n;
    btn_idx_t            col_idx, col_n;
    logic [TW-1:0]       tmo_cnt, tmo_n;
    logic                success_n, inv_n, funds_n, rej_n;

    slot_idx_t           slot;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                activity;
    logic                tmo_hit;
    logic                row_oh, col_oh;
    logic                row_multi, col_multi;

    assign slot      = {row_idx, col_idx};
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
    assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign activity  = coin_valid | (|row_sel) | (|col_sel);
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && !activity;
    assign row_oh    = is_onehot4(row_sel);
    assign col_oh    = is_onehot4(col_sel);
    assign row_multi = (|row_sel) && !row_oh;
    assign col_multi = (|col_sel) && !col_oh;

    vend_price_rom #(
        .CREDIT_W (CREDIT_W)
    ) u_price_rom (
        .slot  (slot),
        .price (price)
    );

    // Next-state, credit, selection and event-pulse decode.
    always_comb begin
        state_n   = state;
        credit_n  = credit;
        price_n   = price_q;
        row_n     = row_idx;
        col_n     = col_idx;
        success_n = 1'b0;
        inv_n     = 1'b0;
        funds_n   = 1'b0;
        rej_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                        state_n  = ST_CREDIT;
                    end else begin
                        rej_n = 1'b1;
                    end
                end
            end
            ST_CREDIT, ST_ROW_LATCHED: begin
                if (coin_valid) begin
                    if (coin_fits) credit_n = coin_sum[CREDIT_W-1:0];
                    else           rej_n    = 1'b1;
                end
                if (cancel || tmo_hit) begin
                    state_n = (credit_n == '0) ? ST_IDLE : ST_CHANGE;
                    row_n   = '0;
                    col_n   = '0;
                end else if (state == ST_CREDIT) begin
                    if (row_oh) begin
                        row_n   = enc4(row_sel);
                        state_n = ST_ROW_LATCHED;
                    end else if (row_multi) begin
                        inv_n = 1'b1;
                    end
                end else begin
                    if (col_oh) begin
                        col_n   = enc4(col_sel);
                        state_n = ST_CHECK;
                    end else if (col_multi) begin
                        inv_n   = 1'b1;
                        row_n   = '0;
                        state_n = ST_CREDIT;
                    end else if (row_oh) begin
                        row_n = enc4(row_sel);
                    end else if (row_multi) begin
                        inv_n = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                rej_n   = coin_valid;
                price_n = price;
                if (credit >= price) begin
                    state_n = ST_VEND;
                end else begin
                    funds_n = 1'b1;
                    row_n   = '0;
                    col_n   = '0;
                    state_n = ST_CREDIT;
                end
            end
            ST_VEND: begin
                rej_n = coin_valid;
                if (vend_done) begin
                    credit_n  = credit - price_q;
                    success_n = 1'b1;
                    row_n     = '0;
                    col_n     = '0;
                    state_n   = (credit_n != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                rej_n = coin_valid;
                if (change_ack) begin
                    credit_n = '0;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                credit_n = '0;
                row_n    = '0;
                col_n    = '0;
            end
        endcase
    end

    // Inactivity counter: only advances while waiting for input.
    always_comb begin
        tmo_n = '0;
        if ((state_n == ST_CREDIT || state_n == ST_ROW_LATCHED) &&
            state_n == state && !activity)
            tmo_n = tmo_cnt + TW'(1);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            price_q     <= '0;
            row_idx     <= '0;
            col_idx     <= '0;
            tmo_cnt     <= '0;
            success     <= 1'b0;
            err_invalid <= 1'b0;
            err_funds   <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            price_q     <= price_n;
            row_idx     <= row_n;
            col_idx     <= col_n;
            tmo_cnt     <= tmo_n;
            success     <= success_n;
            err_invalid <= inv_n;
            err_funds   <= funds_n;
            coin_reject <= rej_n;
        end
    end

    assign vend_req     = (state == ST_VEND);
    assign vend_slot    = vend_req ? slot : 4'd0;
    assign change_valid = (state == ST_CHANGE);
    assign change_out   = change_valid ? credit : '0;
    assign credit_out   = credit;
    assign price_out    = price_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: vector table
// plus hand-written timeout, cancel and async-reset sequences.
module tb_vend_txn_controller;

    localparam int T = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        coin_valid;
    logic [15:0] coin_value;
    logic [3:0]  row_sel;
    logic [3:0]  col_sel;
    logic        cancel;
    logic        vend_req;
    logic [3:0]  vend_slot;
    logic        vend_done;
    logic        change_valid;
    logic [15:0] change_out;
    logic        change_ack;
    logic [15:0] credit_out;
    logic [15:0] price_out;
    logic        success;
    logic        err_invalid;
    logic        err_funds;
    logic        coin_reject;

    int checks = 0;
    int passed = 0;

    vend_txn_controller #(
        .TIMEOUT_CYCLES (T),
        .CREDIT_W       (16),
        .MAX_CREDIT     (1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .row_sel      (row_sel),
        .col_sel      (col_sel),
        .cancel       (cancel),
        .vend_req     (vend_req),
        .vend_slot    (vend_slot),
        .vend_done    (vend_done),
        .change_valid (change_valid),
        .change_out   (change_out),
        .change_ack   (change_ack),
        .credit_out   (credit_out),
        .price_out    (price_out),
        .success      (success),
        .err_invalid  (err_invalid),
        .err_funds    (err_funds),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [15:0] cval;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        can;
        logic        vd;
        logic        ack;
        logic [15:0] cred;
        logic [15:0] price;
        logic        vreq;
        logic [3:0]  slot;
        logic        chv;
        logic [15:0] chg;
        logic [3:0]  pul;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic cv, input int cval, input logic [3:0] row,
        input logic [3:0] col, input logic can, input logic vd,
        input logic ack, input int cred, input int price,
        input logic vreq, input int slot, input logic chv,
        input int chg, input logic [3:0] pul);
        vec_t v;
        v.cv = cv; v.cval = 16'(cval); v.row = row; v.col = col;
        v.can = can; v.vd = vd; v.ack = ack;
        v.cred = 16'(cred); v.price = 16'(price); v.vreq = vreq;
        v.slot = 4'(slot); v.chv = chv; v.chg = 16'(chg); v.pul = pul;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic drive(input logic cv, input int cval,
                         input logic [3:0] row, input logic [3:0] col,
                         input logic can, input logic vd, input logic ack);
        coin_valid = cv;
        coin_value = 16'(cval);
        row_sel    = row;
        col_sel    = col;
        cancel     = can;
        vend_done  = vd;
        change_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [57:0] got, exp;
        drive(v.cv, int'(v.cval), v.row, v.col, v.can, v.vd, v.ack);
        step();
        got = {vend_req, vend_slot, change_valid, change_out, credit_out,
               price_out, success, err_invalid, err_funds, coin_reject};
        exp = {v.vreq, v.slot, v.chv, v.chg, v.cred, v.price, v.pul};
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL vec%0d: got req=%0d slot=%0d chv=%0d chg=%0d cred=%0d price=%0d pulses=%b, expected req=%0d slot=%0d chv=%0d chg=%0d cred=%0d price=%0d pulses=%b",
                     idx, vend_req, vend_slot, change_valid, change_out,
                     credit_out, price_out,
                     {success, err_invalid, err_funds, coin_reject},
                     v.vreq, v.slot, v.chv, v.chg, v.cred, v.price, v.pul);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // pulses = {success, err_invalid, err_funds, coin_reject}
        // exact change: 4x25, A2, coin during VEND rejected
        tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0,  25,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0,  50,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0,  75,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0, 100,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,  0, 1, 0, 0, 0, 0, 100,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,  0, 0, 2, 0, 0, 0, 100,   0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 100, 100, 1, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0, 100, 100, 1, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 100, 100, 1, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0,  0, 0, 0, 0, 1, 0,   0, 100, 0, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0,   0, 100, 0, 0, 0, 0, 4'b0000));
        // change: 200 credit, A3 costs 150
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 100, 100, 0, 0, 0,  0, 4'b0000));
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 200, 100, 0, 0, 0,  0, 4'b0000));
        tbl.push_back(mk(0,   0, 1, 0, 0, 0, 0, 200, 100, 0, 0, 0,  0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 4, 0, 0, 0, 200, 100, 0, 0, 0,  0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 200, 150, 1, 2, 0,  0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 1, 0,  50, 150, 0, 0, 1, 50, 4'b1000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0,  50, 150, 0, 0, 1, 50, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 1,   0, 150, 0, 0, 0,  0, 4'b0000));
        // invalid row, then invalid column after valid A
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 100, 150, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 3, 0, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 1, 0, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 5, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 200, 150, 0, 0, 0, 0, 4'b0000));
        // insufficient funds on B1, then cancel refunds 200
        tbl.push_back(mk(0, 0, 2, 0, 0, 0, 0, 200, 150, 0, 0, 0,   0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 200, 150, 0, 0, 0,   0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 200, 250, 0, 0, 0,   0, 4'b0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 200, 250, 0, 0, 0,   0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 200, 250, 0, 0, 1, 200, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 250, 0, 0, 0,   0, 4'b0000));
        // coin and row together; credit equals price on C2
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 100, 250, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1,  25, 4, 0, 0, 0, 0, 125, 250, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 2, 0, 0, 0, 125, 250, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 125, 125, 1, 9, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 1, 0,   0, 125, 0, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0,   0, 125, 0, 0, 0, 0, 4'b0000));
        // credit ceiling: 1000 accepted, further coin refused
        tbl.push_back(mk(1, 500, 0, 0, 0, 0, 0,  500, 125, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(1, 500, 0, 0, 0, 0, 0, 1000, 125, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(1,  25, 0, 0, 0, 0, 0, 1000, 125, 0, 0, 0,    0, 4'b0001));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 1000, 125, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 1, 0, 0, 1000, 125, 0, 0, 1, 1000, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 1,    0, 125, 0, 0, 0,    0, 4'b0000));
        // row re-latch A -> D, then D1
        tbl.push_back(mk(1, 200, 0, 0, 0, 0, 0, 200, 125, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 1, 0, 0, 0, 0, 200, 125, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 8, 0, 0, 0, 0, 200, 125, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 1, 0, 0, 0, 200, 125, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0, 200, 200, 1, 12, 0, 0, 4'b0000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 1, 0,   0, 200, 0,  0, 0, 0, 4'b1000));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 0,   0, 200, 0,  0, 0, 0, 4'b0000));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_credit", int'(credit_out), 0);
        chk("reset_outputs", int'({vend_req, vend_slot, change_valid,
                                   change_out, price_out, success,
                                   err_invalid, err_funds, coin_reject}), 0);

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // inactivity timeout refunds the full credit
        drive(1, 100, 0, 0, 0, 0, 0);
        step();
        idle(T - 1);
        chk("timeout_not_early", int'(change_valid), 0);
        n = 99;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (change_valid) begin
                n = i;
                break;
            end
        end
        chk("timeout_latency", n, 1);
        chk("timeout_change", int'(change_out), 100);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("timeout_ack_credit", int'(credit_out), 0);

        // cancel after 5 idle cycles
        drive(1, 100, 0, 0, 0, 0, 0);
        step();
        idle(5);
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        chk("cancel_valid", int'(change_valid), 1);
        chk("cancel_change", int'(change_out), 100);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("cancel_ack_valid", int'(change_valid), 0);

        // asynchronous reset in the middle of a vend
        drive(1, 100, 0, 0, 0, 0, 0);
        step();
        drive(1, 50, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 4, 0, 0, 0);
        step();
        idle(1);
        chk("pre_reset_vend_req", int'(vend_req), 1);
        chk("pre_reset_credit", int'(credit_out), 150);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", int'({vend_req, change_valid}), 0);
        chk("async_reset_credit", int'(credit_out), 0);
        step();
        reset = 1'b0;
        drive(0, 0, 1, 1, 0, 0, 0);
        step();
        chk("post_reset_buttons_ignored",
            int'({vend_req, err_invalid, credit_out}), 0);
        drive(1, 25, 0, 0, 0, 0, 0);
        step();
        chk("post_reset_coin", int'(credit_out), 25);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending datapath.
- Accumulates coin credit, latches the row then the column selection, and checks credit against the slot price.
- Drives the dispense-motor handshake, then the change/refund handshake.
- Enforces an inactivity timeout and a cancel-refund path; sits between the front-panel/coin-acceptor inputs and the motor/coin-return actuators.

Parameters:
- TIMEOUT_CYCLES, 1000: inactivity cycles in CREDIT/ROW_LATCHED before automatic refund.
- CREDIT_W, 16: width of credit, price and change values, in cents.
- MAX_CREDIT, 1000: maximum accepted credit in cents; coins beyond this are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- coin_valid  in  1  one-cycle strobe: coin accepted by acceptor.
- coin_value  in  CREDIT_W  coin value in cents, qualified by coin_valid.
- row_sel  in  4  row buttons A..D (bit0=A); pressed means nonzero.
- col_sel  in  4  column buttons 1..4 (bit0=1).
- cancel  in  1  refund request, level.
- vend_req  out  1  dispense request to motor, held until vend_done.
- vend_slot  out  4  slot index = row*4+col (A1=0, A3=2, B1=4, D4=15); valid with vend_req.
- vend_done  in  1  motor completion, sampled only while vend_req=1.
- change_valid  out  1  change/refund amount presented.
- change_out  out  CREDIT_W  amount to return; valid with change_valid.
- change_ack  in  1  coin-return completion.
- credit_out  out  CREDIT_W  current credit, registered.
- price_out  out  CREDIT_W  price of the last rejected or checked selection.
- success  out  1  one-cycle pulse on completed vend.
- err_invalid  out  1  one-cycle pulse: more than one button bit set in row or column.
- err_funds  out  1  one-cycle pulse: credit < price.
- coin_reject  out  1  one-cycle pulse: coin refused.

Behaviour:
- Reset state: all outputs 0; state IDLE; credit 0; timeout counter 0.
- Reset mid-transaction discards the credit; refund on power loss is mechanical and outside this block.

States:
- IDLE: accepted coin adds to credit and moves to CREDIT. Buttons ignored.
- CREDIT:
  - coin_valid: credit += coin_value if the result is <= MAX_CREDIT; otherwise coin_reject pulses and credit is unchanged.
  - row_sel nonzero and one-hot: latch the row index, go to ROW_LATCHED.
  - row_sel nonzero and multi-hot: err_invalid pulses, stay in CREDIT.
- ROW_LATCHED:
  - Coins are handled as in CREDIT.
  - col_sel one-hot: latch the column index, go to CHECK.
  - col_sel multi-hot: err_invalid pulses, return to CREDIT with the row cleared.
  - row_sel changing to a different one-hot value re-latches the row.
- CHECK (exactly 1 cycle): price = PRICE_TABLE[slot]; price_out <= price.
  - credit >= price: go to VEND, vend_req=1, vend_slot driven.
  - credit < price: err_funds pulses, return to CREDIT with selection cleared.
- VEND:
  - Hold vend_req and vend_slot stable until vend_done=1 is sampled.
  - That same edge: credit <= credit - price; success pulses the next cycle.
  - Remainder > 0: go to CHANGE. Remainder = 0: go to IDLE.
  - cancel and coins are ignored; coin_valid raises coin_reject.
- CHANGE:
  - change_valid=1 and change_out=credit, held until change_ack.
  - On change_ack: credit <= 0, change_valid <= 0, go to IDLE.
  - Coins are rejected.

Timeout and cancel:
- The counter runs in CREDIT and ROW_LATCHED only.
- It clears on any coin_valid, any nonzero button, or state entry.
- At TIMEOUT_CYCLES-1, or on cancel=1 (cancel has priority over a same-cycle button), go to CHANGE with the full credit.
- cancel with credit=0 goes to IDLE.

Simultaneous events and arithmetic:
- Coin and button in the same cycle: the coin is accumulated and the button is processed in the same cycle.
- Selection evaluation uses the pre-coin credit; the check happens in the following CHECK cycle with the updated credit.
- All arithmetic is unsigned CREDIT_W. The subtraction cannot underflow because of the CHECK guard.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, CREDIT, ROW_LATCHED, CHECK, VEND, CHANGE);
  - slot index type;
  - PRICE_TABLE constant in cents:
    - row A: 50, 100, 150, 200;
    - row B: 250, 250, 275, 300;
    - row C: 100, 125, 150, 175;
    - row D: 200, 225, 250, 300.
- Sub-module vend_price_rom: combinational slot to price lookup, shared with the display logic.

Test Plan:
- Exact change: coins 4x25, press A then column 2, vend_done after 3 cycles -> vend_slot=1, success pulse, credit_out=0, no change_valid, state IDLE.
- Change: coins 100+100, press A then 3, vend_done -> vend_slot=2, success, change_valid with change_out=50, change_ack -> credit_out=0.
- Invalid selection: credit 200, row_sel=4'b0011 -> err_invalid pulse, credit_out stays 200. Then col_sel=4'b0101 after a valid A -> err_invalid, back to CREDIT.
- Insufficient funds: credit 200, press B then 1 -> err_funds pulse, price_out=250, no vend_req, credit_out=200, state CREDIT.
- Timeout/cancel: coin 100 then idle TIMEOUT_CYCLES -> change_out=100. Repeat with cancel after 5 cycles -> change_out=100. Coin 25 at credit 1000 -> coin_reject.
- Reset: assert reset mid-VEND with credit 150 -> vend_req, credit_out and change_valid go to 0 immediately (asynchronously); state IDLE after release.
